// File: rtl/interrupt_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : interrupt_sequencer
//  Description : 6502-style interrupt/reset entry sequencer. Pushes PCH, PCL
//                and P to the stack page, fetches the NMI/RESET/IRQ vector and
//                loads the PC, stalling the decoder while the sequence runs.
//  Revision    : 1.0  initial release
// ============================================================================
module interrupt_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_enable,
  input  logic        irq,
  input  logic        nmi,
  input  logic        instr_boundary,
  input  logic [15:0] pc_in,
  input  logic [7:0]  sp_in,
  input  logic [6:0]  status_in,
  input  logic [7:0]  data_in,
  output logic        busy,
  output logic [15:0] memory_address,
  output logic        rw,
  output logic [7:0]  data_out,
  output logic        sp_decrement,
  output logic        pc_load,
  output logic [15:0] pc_load_value,
  output logic        set_i_flag,
  output logic        irq_ack
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PUSH_PCH = 3'd1,
    S_PUSH_PCL = 3'd2,
    S_PUSH_P   = 3'd3,
    S_VEC_LO   = 3'd4,
    S_VEC_HI   = 3'd5,
    S_LOAD_PC  = 3'd6
  } state_t;

  localparam logic [15:0] VEC_NMI   = 16'hFFFA;
  localparam logic [15:0] VEC_RESET = 16'hFFFC;
  localparam logic [15:0] VEC_IRQ   = 16'hFFFE;

  state_t      state;
  logic [15:0] vector;
  logic [7:0]  vec_lo;
  logic [7:0]  vec_hi;
  logic        nmi_prev;
  logic        nmi_pending;
  logic        nmi_rise;
  logic        take_interrupt;
  logic        status_b_unused;

  // The pushed status byte always carries B=0, so the incoming B is ignored.
  assign status_b_unused = status_in[4];

  assign nmi_rise       = nmi & ~nmi_prev;
  assign take_interrupt = nmi_pending | (irq & ~status_in[2]);

  // Sequencer state, NMI edge capture and vector/byte latching.
  always_ff @(posedge clk) begin
    if (rst) begin
      // Reset aborts any sequence and jumps straight to the reset-vector fetch.
      state       <= S_VEC_LO;
      vector      <= VEC_RESET;
      vec_lo      <= 8'h00;
      vec_hi      <= 8'h00;
      nmi_prev    <= 1'b0;
      nmi_pending <= 1'b0;
    end else if (clk_enable) begin
      nmi_prev <= nmi;
      // A fresh edge wins over the clear so an edge coinciding with the
      // vector latch is serviced later rather than lost.
      if (nmi_rise) begin
        nmi_pending <= 1'b1;
      end else if (state == S_PUSH_P && nmi_pending) begin
        nmi_pending <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (instr_boundary && take_interrupt) begin
            state <= S_PUSH_PCH;
          end
        end
        S_PUSH_PCH: state <= S_PUSH_PCL;
        S_PUSH_PCL: state <= S_PUSH_P;
        S_PUSH_P: begin
          // Vector is chosen here so a late NMI can hijack an IRQ sequence.
          vector <= nmi_pending ? VEC_NMI : VEC_IRQ;
          state  <= S_VEC_LO;
        end
        S_VEC_LO: begin
          vec_lo <= data_in;
          state  <= S_VEC_HI;
        end
        S_VEC_HI: begin
          vec_hi <= data_in;
          state  <= S_LOAD_PC;
        end
        S_LOAD_PC: state <= S_IDLE;
        default:   state <= S_IDLE;
      endcase
    end
  end

  // Bus and pulse decode from the current state; forced idle while in reset.
  always_comb begin
    busy           = 1'b0;
    memory_address = 16'h0000;
    rw             = 1'b1;
    data_out       = 8'h00;
    sp_decrement   = 1'b0;
    pc_load        = 1'b0;
    set_i_flag     = 1'b0;
    irq_ack        = 1'b0;
    pc_load_value  = {vec_hi, vec_lo};
    if (!rst) begin
      busy = (state != S_IDLE);
      case (state)
        S_PUSH_PCH: begin
          memory_address = {8'h01, sp_in};
          rw             = 1'b0;
          data_out       = pc_in[15:8];
          sp_decrement   = 1'b1;
        end
        S_PUSH_PCL: begin
          memory_address = {8'h01, sp_in};
          rw             = 1'b0;
          data_out       = pc_in[7:0];
          sp_decrement   = 1'b1;
        end
        S_PUSH_P: begin
          memory_address = {8'h01, sp_in};
          rw             = 1'b0;
          data_out       = {status_in[6:5], 2'b10, status_in[3:0]};
          sp_decrement   = 1'b1;
        end
        S_VEC_LO: memory_address = vector;
        S_VEC_HI: memory_address = vector + 16'd1;
        S_LOAD_PC: begin
          pc_load    = 1'b1;
          set_i_flag = 1'b1;
          irq_ack    = (vector == VEC_IRQ);
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_interrupt_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_interrupt_sequencer
//  Description : Self-checking bench for interrupt_sequencer. A queue of
//                expected bus cycles is built whenever a sequence is started
//                and consumed one entry per enabled cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_interrupt_sequencer;

  logic        clk = 1'b0;
  logic        rst, clk_enable, irq, nmi, instr_boundary;
  logic [15:0] pc_in;
  logic [7:0]  sp_in;
  logic [6:0]  status_in;
  logic [7:0]  data_in;
  logic        busy, rw, sp_decrement, pc_load, set_i_flag, irq_ack;
  logic [15:0] memory_address, pc_load_value;
  logic [7:0]  data_out;

  // Vector table FFFA..FFFF; all other reads return 0.
  logic [7:0]  vtab [0:7];
  wire  [15:0] voff = memory_address - 16'hFFFA;
  assign data_in = (memory_address >= 16'hFFFA) ? vtab[voff[2:0]] : 8'h00;

  interrupt_sequencer dut (
    .clk(clk), .rst(rst), .clk_enable(clk_enable), .irq(irq), .nmi(nmi),
    .instr_boundary(instr_boundary), .pc_in(pc_in), .sp_in(sp_in),
    .status_in(status_in), .data_in(data_in), .busy(busy),
    .memory_address(memory_address), .rw(rw), .data_out(data_out),
    .sp_decrement(sp_decrement), .pc_load(pc_load),
    .pc_load_value(pc_load_value), .set_i_flag(set_i_flag), .irq_ack(irq_ack)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] addr;
    logic        chk_addr;
    logic        rw;
    logic [7:0]  dout;
    logic        spdec;
    logic        pcload;
    logic [15:0] pcval;
    logic        seti;
    logic        ack;
    logic        last_push;
  } exp_t;

  exp_t q[$];
  logic m_pend = 1'b0;
  logic m_prev = 1'b0;
  logic saw_pc_load;
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] vbyte(input logic [15:0] a);
    logic [15:0] o;
    o = a - 16'hFFFA;
    return vtab[o[2:0]];
  endfunction

  // Expected reads of a vector pair followed by the PC load.
  task automatic add_vector(input logic [15:0] v);
    exp_t e;
    e = '0; e.addr = v; e.chk_addr = 1'b1; e.rw = 1'b1;
    q.push_back(e);
    e.addr = v + 16'd1;
    q.push_back(e);
    e = '0; e.rw = 1'b1; e.pcload = 1'b1; e.seti = 1'b1;
    e.ack = (v == 16'hFFFE);
    e.pcval = {vbyte(v + 16'd1), vbyte(v)};
    q.push_back(e);
  endtask

  task automatic add_push(input logic [7:0] b, input logic last);
    exp_t e;
    e = '0; e.addr = {8'h01, sp_in}; e.chk_addr = 1'b1; e.rw = 1'b0;
    e.dout = b; e.spdec = 1'b1; e.last_push = last;
    q.push_back(e);
  endtask

  // Advance the reference model across one rising edge using current inputs.
  task automatic model_edge();
    exp_t e;
    logic nmi_rise;
    if (rst) begin
      q.delete();
      m_pend = 1'b0;
      m_prev = 1'b0;
      add_vector(16'hFFFC);
    end else if (clk_enable) begin
      nmi_rise = nmi && !m_prev;
      m_prev = nmi;
      if (q.size() != 0) begin
        e = q.pop_front();
        if (e.last_push) begin
          add_vector(m_pend ? 16'hFFFA : 16'hFFFE);
          m_pend = 1'b0;
        end
      end else if (instr_boundary && (m_pend || (irq && !status_in[2]))) begin
        add_push(pc_in[15:8], 1'b0);
        add_push(pc_in[7:0], 1'b0);
        add_push({status_in[6:5], 2'b10, status_in[3:0]}, 1'b1);
      end
      if (nmi_rise) m_pend = 1'b1;
    end
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic tick(input string tag);
    exp_t e;
    logic ebusy;
    logic [29:0] obs, expv;
    #1;
    if (rst || q.size() == 0) begin
      e = '0; e.rw = 1'b1; e.chk_addr = 1'b1; ebusy = 1'b0;
    end else begin
      e = q[0]; ebusy = 1'b1;
    end
    obs  = {busy, (e.chk_addr ? memory_address : 16'h0), rw, data_out,
            sp_decrement, pc_load, set_i_flag, irq_ack};
    expv = {ebusy, (e.chk_addr ? e.addr : 16'h0), e.rw, e.dout,
            e.spdec, e.pcload, e.seti, e.ack};
    check(tag, 32'(obs), 32'(expv));
    if (!rst && e.pcload) check({tag, "/pc_value"}, 32'(pc_load_value), 32'(e.pcval));
    saw_pc_load = pc_load;
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  task automatic boundary_pulse(input string tag);
    instr_boundary = 1'b1;
    tick(tag);
    instr_boundary = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic found;
    rst = 1'b1; clk_enable = 1'b1; irq = 1'b0; nmi = 1'b0; instr_boundary = 1'b0;
    pc_in = 16'h0000; sp_in = 8'hFF; status_in = 7'b0000100;
    vtab[0] = 8'hCD; vtab[1] = 8'hAB; vtab[2] = 8'h34; vtab[3] = 8'h12;
    vtab[4] = 8'h78; vtab[5] = 8'h56; vtab[6] = 8'h00; vtab[7] = 8'h00;

    // Reset state and reset-vector fetch (1234)
    run("reset_hold", 3);
    rst = 1'b0;
    run("reset_vector", 5);

    // IRQ dispatch: writes C0/DE/A3 to 01FD, vector FFFE, irq_ack, 6 cycles
    status_in = 7'b1000011; pc_in = 16'hC0DE; sp_in = 8'hFD;
    irq = 1'b1;
    boundary_pulse("irq_boundary");
    irq = 1'b0;
    lat = 0; found = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      if (!found) begin
        tick("irq_seq");
        if (saw_pc_load) begin lat = k; found = 1'b1; end
      end
    end
    check("irq_latency", 32'(lat), 32'd6);
    run("irq_after", 2);

    // Masked IRQ over 20 boundaries
    status_in = 7'b0000100; irq = 1'b1;
    for (int k = 0; k < 20; k++) begin
      boundary_pulse("masked_irq");
      tick("masked_irq");
    end
    irq = 1'b0;

    // NMI hijack of an IRQ sequence, nmi then held high across boundaries
    status_in = 7'b0000000; pc_in = 16'h1357; sp_in = 8'hF0;
    irq = 1'b1;
    boundary_pulse("hijack_boundary");
    irq = 1'b0;
    tick("hijack_pch");
    nmi = 1'b1;
    run("hijack_seq", 7);
    for (int k = 0; k < 5; k++) begin
      boundary_pulse("nmi_held");
      tick("nmi_held");
    end
    nmi = 1'b0;
    run("nmi_release", 2);

    // IRQ and NMI edge in the same boundary; IRQ served afterwards
    irq = 1'b1; nmi = 1'b1;
    boundary_pulse("same_cycle");
    run("same_cycle_seq", 7);
    boundary_pulse("irq_later");
    irq = 1'b0;
    run("irq_later_seq", 7);
    nmi = 1'b0;

    // NMI edge after vector fetch started stays pending
    irq = 1'b1;
    boundary_pulse("late_nmi_boundary");
    irq = 1'b0;
    run("late_nmi_seq", 4);
    nmi = 1'b1;
    run("late_nmi_seq", 3);
    nmi = 1'b0;
    boundary_pulse("late_nmi_service");
    run("late_nmi_service", 7);

    // Reset during the status push
    irq = 1'b1;
    boundary_pulse("rst_mid_boundary");
    irq = 1'b0;
    run("rst_mid_seq", 2);
    rst = 1'b1;
    tick("rst_mid_assert");
    rst = 1'b0;
    run("rst_mid_vector", 5);

    // clk_enable held low for 3 cycles in the high-byte vector read
    irq = 1'b1;
    boundary_pulse("stall_boundary");
    irq = 1'b0;
    run("stall_seq", 4);
    clk_enable = 1'b0;
    run("stall_hold", 3);
    clk_enable = 1'b1;
    run("stall_resume", 4);

    // Randomized traffic
    for (int k = 0; k < 500; k++) begin
      if (q.size() == 0) begin
        pc_in = 16'($urandom);
        sp_in = 8'($urandom);
        status_in = 7'($urandom);
        for (int i = 0; i < 6; i++) vtab[i] = 8'($urandom);
      end
      rst            = ($urandom_range(99) < 2);
      clk_enable     = ($urandom_range(99) < 85);
      irq            = ($urandom_range(99) < 50);
      instr_boundary = ($urandom_range(99) < 30);
      if ($urandom_range(99) < 8) nmi = ~nmi;
      tick("random");
    end
    rst = 1'b0; clk_enable = 1'b1; irq = 1'b0; instr_boundary = 1'b0;
    run("random_drain", 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
